// File: rtl/exe_collector.sv
// exe_collector: merges per-FU result lanes into one registered writeback bundle with
// round-robin FU priority. Define EXE_COLLECTOR_STAT_EN to add stat_wb/stat_conflict counters.
package exe_collector_pkg;
    typedef struct packed {
        logic [15:0] opid;  // bit 15 marks a valid lane
        logic [31:0] data;
    } exe_bundle_t;
endpackage

module exe_collector
    import exe_collector_pkg::*;
#(
    parameter int nfu = 2,
    parameter int ewd = 4,
    parameter int wbw = 4,
    localparam int PW = (nfu > 1) ? $clog2(nfu) : 1,
    localparam int NW = $clog2(wbw) + 1,
    localparam int CW = $clog2(nfu * ewd) + 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  exe_bundle_t [nfu-1:0][ewd-1:0]  resp,
    output logic        [nfu-1:0][ewd-1:0]  claim,
    input  logic                            stall,
    output exe_bundle_t [wbw-1:0]           wb,
    output logic        [NW-1:0]            wb_num,
`ifdef EXE_COLLECTOR_STAT_EN
    output logic        [63:0]              stat_wb,
    output logic        [63:0]              stat_conflict,
`endif
    output logic        [PW-1:0]            o_dbg_ptr
);

    logic [PW-1:0]                r_ptr;
    logic [nfu-1:0][ewd-1:0]      w_claim;
    exe_bundle_t [wbw-1:0]        w_packed;
    logic [CW-1:0]                w_total;
    logic [CW-1:0]                w_sum_v;
    logic                         w_take;

    // Handshake: an FU lane is offered while opid[15]=1; claim[f][i]=1 pops it at the
    // next clk edge, and the popped lane appears on wb right after that same edge.
    assign w_take = !stall && !flush && !rst;

    always_comb begin
        int f;
        int nv;
        int g;
        int rem;
        int slot;
        f        = 0;
        nv       = 0;
        g        = 0;
        rem      = wbw;
        slot     = 0;
        w_claim  = '0;
        w_packed = '0;
        w_total  = '0;
        w_sum_v  = '0;
        for (int k = 0; k < nfu; k++) begin
            f  = (int'(r_ptr) + k) % nfu;
            // Only the contiguous valid prefix counts; anything past a hole waits.
            nv = ewd;
            for (int i = ewd - 1; i >= 0; i--) begin
                if (!resp[f][i].opid[15]) nv = i;
            end
            g = (nv < rem) ? nv : rem;
            for (int i = 0; i < ewd; i++) begin
                if (i < g) begin
                    w_claim[f][i] = 1'b1;
                    if (slot < wbw) w_packed[slot] = resp[f][i];
                    slot = slot + 1;
                end
            end
            rem     = rem - g;
            w_total = w_total + CW'(g);
            w_sum_v = w_sum_v + CW'(nv);
        end
    end

    assign claim     = w_take ? w_claim : '0;
    assign o_dbg_ptr = r_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wb     <= '0;
            wb_num <= '0;
            r_ptr  <= '0;
        end else if (!stall) begin
            wb     <= w_packed;
            wb_num <= NW'(w_total);
            if (w_total != '0) begin
                r_ptr <= (r_ptr == PW'(nfu - 1)) ? '0 : r_ptr + 1'b1;
            end
        end
    end

`ifdef EXE_COLLECTOR_STAT_EN
    logic [63:0] r_stat_wb;
    logic [63:0] r_stat_conflict;

    // Statistics survive flush; only rst clears them. Both saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_wb       <= '0;
            r_stat_conflict <= '0;
        end else if (w_take) begin
            r_stat_wb <= (r_stat_wb > (~64'd0 - 64'(w_total))) ? '1 : r_stat_wb + 64'(w_total);
            if ((w_sum_v > w_total) && (r_stat_conflict != '1)) begin
                r_stat_conflict <= r_stat_conflict + 64'd1;
            end
        end
    end

    assign stat_wb       = r_stat_wb;
    assign stat_conflict = r_stat_conflict;
`else
    logic w_unused_sum;
    assign w_unused_sum = ^w_sum_v;
`endif

endmodule

// File: tb/tb_exe_collector.sv
// tb_exe_collector: vector table, hand-written multi-cycle sequences and randomized FU-queue
// traffic, all checked against a queue-based reference model of the collector.
`timescale 1ns/1ps
module tb_exe_collector;
    import exe_collector_pkg::*;

    localparam int NFU = 2;
    localparam int EWD = 4;
    localparam int WBW = 4;

    logic                            clk = 1'b0;
    logic                            rst;
    logic                            flush;
    logic                            stall;
    exe_bundle_t [NFU-1:0][EWD-1:0]  resp;
    logic        [NFU-1:0][EWD-1:0]  claim;
    exe_bundle_t [WBW-1:0]           wb;
    logic        [$clog2(WBW):0]     wb_num;
    logic        [0:0]               dbg_ptr;
`ifdef EXE_COLLECTOR_STAT_EN
    logic        [63:0]              stat_wb;
    logic        [63:0]              stat_conflict;
`endif

    exe_collector #(.nfu(NFU), .ewd(EWD), .wbw(WBW)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .resp          (resp),
        .claim         (claim),
        .stall         (stall),
        .wb            (wb),
        .wb_num        (wb_num),
`ifdef EXE_COLLECTOR_STAT_EN
        .stat_wb       (stat_wb),
        .stat_conflict (stat_conflict),
`endif
        .o_dbg_ptr     (dbg_ptr)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200us");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    exe_bundle_t             m_wb [WBW];
    int                      m_num;
    int                      m_ptr;
    logic [63:0]             m_swb;
    logic [63:0]             m_scf;
    exe_bundle_t             n_wb [WBW];
    int                      n_num;
    int                      n_ptr;
    logic [63:0]             n_swb;
    logic [63:0]             n_scf;
    logic [NFU-1:0][EWD-1:0] m_claim;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] sat_add(input logic [63:0] a, input int b);
        logic [64:0] s;
        s = {1'b0, a} + 65'(b);
        return s[64] ? '1 : s[63:0];
    endfunction

    // Visit FUs from the pointer, hand each its valid prefix while slots remain,
    // and append granted lanes to a queue that becomes the next bundle.
    task automatic model_eval();
        int v [NFU];
        int sumv;
        int rem;
        int f;
        int g;
        exe_bundle_t pk [$];
        m_claim = '0;
        n_num   = m_num;
        n_ptr   = m_ptr;
        n_swb   = m_swb;
        n_scf   = m_scf;
        foreach (n_wb[s]) n_wb[s] = m_wb[s];
        sumv = 0;
        for (int k = 0; k < NFU; k++) begin
            v[k] = 0;
            while (v[k] < EWD && resp[k][v[k]].opid[15]) v[k]++;
            sumv += v[k];
        end
        if (rst || flush) begin
            foreach (n_wb[s]) n_wb[s] = '0;
            n_num = 0;
            n_ptr = 0;
            if (rst) begin
                n_swb = '0;
                n_scf = '0;
            end
        end else if (!stall) begin
            rem = WBW;
            for (int k = 0; k < NFU; k++) begin
                f = (m_ptr + k) % NFU;
                g = (v[f] < rem) ? v[f] : rem;
                for (int i = 0; i < g; i++) begin
                    m_claim[f][i] = 1'b1;
                    pk.push_back(resp[f][i]);
                end
                rem -= g;
            end
            foreach (n_wb[s]) begin
                if (s < pk.size()) n_wb[s] = pk[s];
                else               n_wb[s] = '0;
            end
            n_num = pk.size();
            if (n_num > 0) n_ptr = (m_ptr + 1) % NFU;
            n_swb = sat_add(m_swb, n_num);
            if (sumv > n_num) n_scf = sat_add(m_scf, 1);
        end
    endtask

    task automatic half_eval(input string tag);
        @(negedge clk);
        model_eval();
        check({tag, ".claim"}, 64'(claim), 64'(m_claim));
    endtask

    task automatic half_commit(input string tag);
        @(posedge clk);
        #1;
        m_wb  = n_wb;
        m_num = n_num;
        m_ptr = n_ptr;
        m_swb = n_swb;
        m_scf = n_scf;
        check({tag, ".wb_num"}, 64'(wb_num), 64'(m_num));
        check({tag, ".ptr"}, 64'(dbg_ptr), 64'(m_ptr));
        for (int s = 0; s < WBW; s++) begin
            check($sformatf("%s.wb[%0d]", tag, s), 64'(wb[s]), 64'(m_wb[s]));
        end
`ifdef EXE_COLLECTOR_STAT_EN
        check({tag, ".stat_wb"}, stat_wb, m_swb);
        check({tag, ".stat_conflict"}, stat_conflict, m_scf);
`endif
    endtask

    // Invalid lanes carry junk in the low opid bits so only bit 15 can mark validity.
    function automatic exe_bundle_t mk_lane(input int f, input int i, input bit vld, input int tag);
        exe_bundle_t b;
        b.opid = {vld, 3'b0, 4'(f), 4'(i), 4'(tag)};
        b.data = $urandom;
        return b;
    endfunction

    task automatic set_masks(input logic [EWD-1:0] m0, input logic [EWD-1:0] m1, input int tag);
        for (int i = 0; i < EWD; i++) begin
            resp[0][i] = mk_lane(0, i, m0[i], tag);
            resp[1][i] = mk_lane(1, i, m1[i], tag);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [EWD-1:0] m0;
        logic [EWD-1:0] m1;
        bit             st;
        bit             fl;
        logic [EWD-1:0] c0;
        logic [EWD-1:0] c1;
        int             num;
        int             ptr;
    } vec_t;

    function automatic vec_t mkv(input logic [3:0] m0, input logic [3:0] m1, input bit st,
                                 input bit fl, input logic [3:0] c0, input logic [3:0] c1,
                                 input int num, input int ptr);
        vec_t t;
        t.m0 = m0; t.m1 = m1; t.st = st; t.fl = fl;
        t.c0 = c0; t.c1 = c1; t.num = num; t.ptr = ptr;
        return t;
    endfunction

    // ---------------- randomized FU queues + scoreboard ----------------
    exe_bundle_t fq [NFU][$];
    logic [15:0] exp_q [NFU][$];
    int          seq [NFU];

    task automatic rnd_cycle(input bit gen);
        logic [NFU-1:0][EWD-1:0] cl;
        exe_bundle_t b;
        bit load;
        int f;
        if (gen) begin
            for (int q = 0; q < NFU; q++) begin
                int n;
                n = $urandom_range(0, 2);
                for (int j = 0; j < n; j++) begin
                    if (fq[q].size() < 12) begin
                        b.opid = {1'b1, 3'b0, 4'(q), 8'(seq[q])};
                        b.data = $urandom;
                        seq[q]++;
                        fq[q].push_back(b);
                        exp_q[q].push_back(b.opid);
                    end
                end
            end
        end
        for (int q = 0; q < NFU; q++) begin
            for (int i = 0; i < EWD; i++) begin
                if (i < fq[q].size()) resp[q][i] = fq[q][i];
                else                  resp[q][i] = {1'b0, 15'($urandom), 32'($urandom)};
            end
        end
        stall = gen && ($urandom_range(0, 3) == 0);
        flush = gen && ($urandom_range(0, 39) == 0);
        load  = !stall && !flush;
        half_eval("rnd");
        cl = claim;
        half_commit("rnd");
        for (int q = 0; q < NFU; q++) begin
            for (int i = 0; i < EWD; i++) begin
                if (cl[q][i] && fq[q].size() > 0) void'(fq[q].pop_front());
            end
        end
        if (flush) begin
            for (int q = 0; q < NFU; q++) begin
                fq[q].delete();
                exp_q[q].delete();
            end
        end
        if (load) begin
            for (int s = 0; s < m_num; s++) begin
                f = int'(m_wb[s].opid[11:8]);
                check("sb.avail", 64'(exp_q[f].size() > 0), 64'd1);
                if (exp_q[f].size() > 0) check("sb.order", 64'(wb[s].opid), 64'(exp_q[f].pop_front()));
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vec_t        tbl [20];
        logic [7:0]  ord [4];
        logic [63:0] base_wb;
        logic [63:0] base_cf;

        foreach (m_wb[s]) m_wb[s] = '0;
        m_num = 0; m_ptr = 0; m_swb = '0; m_scf = '0;
        foreach (seq[q]) seq[q] = 0;

        tbl[0]  = mkv(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 0, 0);
        tbl[1]  = mkv(4'h7, 4'h3, 1'b0, 1'b0, 4'h7, 4'h1, 4, 1);
        tbl[2]  = mkv(4'h0, 4'h1, 1'b0, 1'b0, 4'h0, 4'h1, 1, 0);
        tbl[3]  = mkv(4'hF, 4'hF, 1'b1, 1'b0, 4'h0, 4'h0, 1, 0);
        tbl[4]  = mkv(4'hF, 4'hF, 1'b1, 1'b0, 4'h0, 4'h0, 1, 0);
        tbl[5]  = mkv(4'hF, 4'hF, 1'b1, 1'b0, 4'h0, 4'h0, 1, 0);
        tbl[6]  = mkv(4'hF, 4'hF, 1'b0, 1'b0, 4'hF, 4'h0, 4, 1);
        tbl[7]  = mkv(4'hF, 4'hF, 1'b0, 1'b0, 4'h0, 4'hF, 4, 0);
        tbl[8]  = mkv(4'h7, 4'h1, 1'b0, 1'b0, 4'h7, 4'h1, 4, 1);
        tbl[9]  = mkv(4'h0, 4'h1, 1'b0, 1'b0, 4'h0, 4'h1, 1, 0);
        tbl[10] = mkv(4'h3, 4'h1, 1'b0, 1'b0, 4'h3, 4'h1, 3, 1);
        tbl[11] = mkv(4'hF, 4'hF, 1'b0, 1'b1, 4'h0, 4'h0, 0, 0);
        tbl[12] = mkv(4'hF, 4'h0, 1'b0, 1'b0, 4'hF, 4'h0, 4, 1);
        tbl[13] = mkv(4'hF, 4'hF, 1'b1, 1'b1, 4'h0, 4'h0, 0, 0);
        tbl[14] = mkv(4'h5, 4'h0, 1'b0, 1'b0, 4'h1, 4'h0, 1, 1);
        tbl[15] = mkv(4'h5, 4'hA, 1'b0, 1'b0, 4'h1, 4'h0, 1, 0);
        tbl[16] = mkv(4'h0, 4'hE, 1'b0, 1'b0, 4'h0, 4'h0, 0, 0);
        tbl[17] = mkv(4'h3, 4'hF, 1'b0, 1'b0, 4'h3, 4'h3, 4, 1);
        tbl[18] = mkv(4'hF, 4'h7, 1'b0, 1'b0, 4'h1, 4'h7, 4, 0);
        tbl[19] = mkv(4'hF, 4'hF, 1'b1, 1'b0, 4'h0, 4'h0, 4, 0);
        ord[0] = 8'h00; ord[1] = 8'h01; ord[2] = 8'h02; ord[3] = 8'h10;

        // Reset: claims must stay low even with full FUs during rst.
        rst = 1'b1; flush = 1'b0; stall = 1'b0;
        set_masks(4'h0, 4'h0, 0);
        repeat (2) @(posedge clk);
        #1;
        set_masks(4'hF, 4'hF, 0);
        half_eval("rst");
        half_commit("rst");
        rst = 1'b0;
        set_masks(4'h0, 4'h0, 0);
        for (int k = 0; k < 3; k++) begin
            half_eval("idle");
            half_commit("idle");
        end

        for (int r = 0; r < 20; r++) begin
            set_masks(tbl[r].m0, tbl[r].m1, r);
            stall = tbl[r].st;
            flush = tbl[r].fl;
            half_eval($sformatf("tbl%0d", r));
            check($sformatf("tbl%0d.claim_vec", r), 64'(claim), 64'({tbl[r].c1, tbl[r].c0}));
            half_commit($sformatf("tbl%0d", r));
            check($sformatf("tbl%0d.num_vec", r), 64'(wb_num), 64'(tbl[r].num));
            check($sformatf("tbl%0d.ptr_vec", r), 64'(dbg_ptr), 64'(tbl[r].ptr));
            if (r == 1) begin
                for (int s = 0; s < WBW; s++) begin
                    check($sformatf("tbl1.order[%0d]", s), 64'(wb[s].opid[11:4]), 64'(ord[s]));
                end
            end
        end

        // Both FUs saturated: grants alternate FU0/FU1, four lanes every cycle.
        stall = 1'b0;
        flush = 1'b1;
        set_masks(4'hF, 4'hF, 9);
        half_eval("full_flush");
        half_commit("full_flush");
        flush   = 1'b0;
        base_wb = m_swb;
        base_cf = m_scf;
        for (int k = 0; k < 4; k++) begin
            set_masks(4'hF, 4'hF, 10 + k);
            half_eval("full");
            check($sformatf("full%0d.claim_alt", k), 64'(claim), (k % 2 == 0) ? 64'h0F : 64'hF0);
            half_commit("full");
`ifdef EXE_COLLECTOR_STAT_EN
            check($sformatf("full%0d.stat_wb_step", k), stat_wb, base_wb + 64'(4 * (k + 1)));
            check($sformatf("full%0d.stat_cf_step", k), stat_conflict, base_cf + 64'(k + 1));
`endif
        end

        for (int c = 0; c < 600; c++) rnd_cycle(1'b1);
        for (int c = 0; c < 16; c++) rnd_cycle(1'b0);
        for (int q = 0; q < NFU; q++) begin
            check($sformatf("drain.fq%0d", q), 64'(fq[q].size()), 64'd0);
            check($sformatf("drain.exp_q%0d", q), 64'(exp_q[q].size()), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
